// File: rtl/adder_fp_pipe.sv
// IEEE-754 add/subtract, flush-to-zero, RNE or RTZ rounding; unpack/align -> add/LZC -> normalise/round/pack.
// Latency: 3 advancing cycles from i_valid to o_valid, one operation per cycle, no bubbles.
// Backpressure: i_en low freezes every stage register including valids; there are no internal stalls.
module adder_fp_pipe #(
    parameter int SIZE     = 32,
    parameter int EXPONENT = 5 + ($clog2(SIZE) - 4) * 3,
    parameter int FRACTION = SIZE - EXPONENT - 1,
    parameter int BIAS     = 2 ** (EXPONENT - 1) - 1
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_en,
    input  logic            i_valid,
    input  logic [SIZE-1:0] i_A,
    input  logic [SIZE-1:0] i_B,
    input  logic            i_sub,
    input  logic            i_rnd,
    output logic            o_valid,
    output logic [SIZE-1:0] o_result,
    output logic [3:0]      o_flags
);

    localparam int SW       = FRACTION + 4;     // hidden bit + fraction + guard/round/sticky
    localparam int LW       = $clog2(SW + 1);
    localparam int XW       = EXPONENT + 2;     // two's-complement working exponent
    localparam int EXP_ALL1 = 2 * BIAS + 1;
    localparam logic [EXPONENT-1:0] SHIFT_MAX = EXPONENT'(FRACTION + 3);
    localparam logic [XW-1:0]       EXP_OVF   = XW'(EXP_ALL1);
    localparam logic [SIZE-1:0]     QNAN      = {1'b0, {EXPONENT{1'b1}}, 1'b1, {(FRACTION-1){1'b0}}};

    typedef struct packed {
        logic                special;
        logic [SIZE-1:0]     spec_res;
        logic [3:0]          spec_flags;
        logic                sign;
        logic [EXPONENT-1:0] exp;
        logic [SW-1:0]       mx;
        logic [SW-1:0]       my;
        logic                eff_sub;
        logic                rnd;
    } align_t;

    typedef struct packed {
        logic                special;
        logic [SIZE-1:0]     spec_res;
        logic [3:0]          spec_flags;
        logic                sign;
        logic [EXPONENT-1:0] exp;
        logic [SW:0]         sum;
        logic [LW-1:0]       lzc;
        logic                rnd;
    } sum_t;

    function automatic logic [LW-1:0] count_lz(input logic [SW-1:0] v);
        logic [LW-1:0] n;
        logic          found;
        n     = LW'(SW);
        found = 1'b0;
        for (int i = SW - 1; i >= 0; i--) begin
            if (!found && v[i]) begin
                n     = LW'(SW - 1 - i);
                found = 1'b1;
            end
        end
        return n;
    endfunction

    align_t s1_d, s1_q;
    sum_t   s2_d, s2_q;
    logic   s1_vld, s2_vld;

    logic                sa, sb, a_zero, b_zero, a_nan, b_nan, a_snan, b_snan, a_inf, b_inf, a_ge;
    logic [EXPONENT-1:0] ea, eb, ex, ey, diff;
    logic [FRACTION-1:0] fa, fb;
    logic [SW-1:0]       sig_a, sig_b, sig_x, sig_y, shifted;
    logic                sticky;

    assign sa     = i_A[SIZE-1];
    assign ea     = i_A[SIZE-2 -: EXPONENT];
    assign fa     = i_A[FRACTION-1:0];
    assign sb     = i_B[SIZE-1] ^ i_sub;
    assign eb     = i_B[SIZE-2 -: EXPONENT];
    assign fb     = i_B[FRACTION-1:0];

    // Zero exponent means zero or subnormal; both are flushed to a signed zero.
    assign a_zero = ~|ea;
    assign b_zero = ~|eb;
    assign a_nan  = (&ea) & (|fa);
    assign b_nan  = (&eb) & (|fb);
    assign a_snan = a_nan & ~fa[FRACTION-1];
    assign b_snan = b_nan & ~fb[FRACTION-1];
    assign a_inf  = (&ea) & ~|fa;
    assign b_inf  = (&eb) & ~|fb;
    assign sig_a  = a_zero ? '0 : {1'b1, fa, 3'b000};
    assign sig_b  = b_zero ? '0 : {1'b1, fb, 3'b000};
    assign a_ge   = (a_zero ? '0 : {ea, fa}) >= (b_zero ? '0 : {eb, fb});
    assign ex     = a_ge ? ea : eb;
    assign ey     = a_ge ? eb : ea;
    assign sig_x  = a_ge ? sig_a : sig_b;
    assign sig_y  = a_ge ? sig_b : sig_a;
    assign diff   = ex - ey;
    assign shifted = sig_y >> diff;
    assign sticky  = |(sig_y & ~({SW{1'b1}} << diff));

    always_comb begin
        s1_d         = '0;
        s1_d.sign    = a_ge ? sa : sb;
        s1_d.exp     = ex;
        s1_d.mx      = sig_x;
        s1_d.my      = (diff >= SHIFT_MAX) ? {{(SW-1){1'b0}}, |sig_y}
                                           : (shifted | {{(SW-1){1'b0}}, sticky});
        s1_d.eff_sub = sa ^ sb;
        s1_d.rnd     = i_rnd;
        if (a_nan | b_nan) begin
            s1_d.special    = 1'b1;
            s1_d.spec_res   = QNAN;
            s1_d.spec_flags = {a_snan | b_snan, 3'b000};
        end else if (a_inf & b_inf & (sa ^ sb)) begin
            s1_d.special    = 1'b1;
            s1_d.spec_res   = QNAN;
            s1_d.spec_flags = 4'b1000;
        end else if (a_inf) begin
            s1_d.special  = 1'b1;
            s1_d.spec_res = {sa, {EXPONENT{1'b1}}, {FRACTION{1'b0}}};
        end else if (b_inf) begin
            s1_d.special  = 1'b1;
            s1_d.spec_res = {sb, {EXPONENT{1'b1}}, {FRACTION{1'b0}}};
        end else if (a_zero & b_zero) begin
            s1_d.special  = 1'b1;
            s1_d.spec_res = {sa & sb, {(SIZE-1){1'b0}}};
        end
    end

    // X is never smaller than the aligned Y, so the difference cannot go negative.
    always_comb begin
        s2_d            = '0;
        s2_d.special    = s1_q.special;
        s2_d.spec_res   = s1_q.spec_res;
        s2_d.spec_flags = s1_q.spec_flags;
        s2_d.sign       = s1_q.sign;
        s2_d.exp        = s1_q.exp;
        s2_d.rnd        = s1_q.rnd;
        s2_d.sum        = s1_q.eff_sub ? ({1'b0, s1_q.mx} - {1'b0, s1_q.my})
                                       : ({1'b0, s1_q.mx} + {1'b0, s1_q.my});
        s2_d.lzc        = count_lz(s2_d.sum[SW-1:0]);
    end

    logic [SW-1:0]       norm;
    logic [XW-1:0]       exp_n, exp_r;
    logic [FRACTION+1:0] mant;
    logic [FRACTION-1:0] frac_r;
    logic                g_bit, r_bit, s_bit, round_up, inexact;
    logic [SIZE-1:0]     res_d;
    logic [3:0]          flags_d;

    always_comb begin
        norm  = '0;
        exp_n = '0;
        if (s2_q.sum[SW]) begin
            norm  = {s2_q.sum[SW:2], s2_q.sum[1] | s2_q.sum[0]};
            exp_n = XW'(s2_q.exp) + XW'(1);
        end else begin
            norm  = s2_q.sum[SW-1:0] << s2_q.lzc;
            exp_n = XW'(s2_q.exp) - XW'(s2_q.lzc);
        end
        g_bit    = norm[2];
        r_bit    = norm[1];
        s_bit    = norm[0];
        inexact  = g_bit | r_bit | s_bit;
        round_up = ~s2_q.rnd & g_bit & (r_bit | s_bit | norm[3]);
        mant     = {1'b0, norm[SW-1:3]} + {{(FRACTION+1){1'b0}}, round_up};
        exp_r    = exp_n + {{(XW-1){1'b0}}, mant[FRACTION+1]};
        frac_r   = mant[FRACTION+1] ? mant[FRACTION:1] : mant[FRACTION-1:0];
        res_d    = {s2_q.sign, exp_r[EXPONENT-1:0], frac_r};
        flags_d  = {3'b000, inexact};
        if (s2_q.special) begin
            res_d   = s2_q.spec_res;
            flags_d = s2_q.spec_flags;
        end else if (s2_q.sum == '0) begin
            res_d   = '0;
            flags_d = 4'b0000;
        end else if (!exp_r[XW-1] && exp_r >= EXP_OVF) begin
            res_d   = s2_q.rnd ? {s2_q.sign, {(EXPONENT-1){1'b1}}, 1'b0, {FRACTION{1'b1}}}
                               : {s2_q.sign, {EXPONENT{1'b1}}, {FRACTION{1'b0}}};
            flags_d = 4'b0101;
        end else if (exp_r[XW-1] || exp_r == '0) begin
            res_d   = {s2_q.sign, {(SIZE-1){1'b0}}};
            flags_d = 4'b0011;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            s1_vld   <= 1'b0;
            s2_vld   <= 1'b0;
            o_valid  <= 1'b0;
            o_result <= '0;
            o_flags  <= '0;
        end else if (i_en) begin
            s1_vld  <= i_valid;
            s2_vld  <= s1_vld;
            o_valid <= s2_vld;
            if (s2_vld) begin
                o_result <= res_d;
                o_flags  <= flags_d;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_en) begin
            s1_q <= s1_d;
            s2_q <= s2_d;
        end
    end

endmodule

// File: tb/tb_adder_fp_pipe.sv
// Bench for adder_fp_pipe (SIZE=32): directed vectors, scripted stall/reset sequences, and a
// randomized stream scored against an exact wide-integer reference model.
module tb_adder_fp_pipe;

    logic        clk = 1'b0;
    logic        i_rst, i_en, i_valid, i_sub, i_rnd;
    logic [31:0] i_A, i_B;
    logic        o_valid;
    logic [31:0] o_result;
    logic [3:0]  o_flags;

    int checks   = 0;
    int failures = 0;
    logic [35:0] exp_q[$];

    adder_fp_pipe dut (
        .i_clk   (clk),
        .i_rst   (i_rst),
        .i_en    (i_en),
        .i_valid (i_valid),
        .i_A     (i_A),
        .i_B     (i_B),
        .i_sub   (i_sub),
        .i_rnd   (i_rnd),
        .o_valid (o_valid),
        .o_result(o_result),
        .o_flags (o_flags)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Exact reference: each operand becomes an integer in units of 2^-149, summed exactly,
    // then rounded once to 24 significant bits.
    function automatic logic [35:0] model(input logic [31:0] a, input logic [31:0] b,
                                          input logic sub, input logic rnd);
        logic sa, sb, za, zb, na, nb, sna, snb, ia, ib, sgn, up, inx;
        logic [299:0] ma, mb, mag, rem, half, one, mant;
        int p, e, sh;
        sa  = a[31];
        sb  = b[31] ^ sub;
        na  = (a[30:23] == 8'hFF) && (a[22:0] != 0);
        nb  = (b[30:23] == 8'hFF) && (b[22:0] != 0);
        sna = na && !a[22];
        snb = nb && !b[22];
        ia  = (a[30:23] == 8'hFF) && (a[22:0] == 0);
        ib  = (b[30:23] == 8'hFF) && (b[22:0] == 0);
        za  = (a[30:23] == 0);
        zb  = (b[30:23] == 0);
        if (na || nb) return {sna || snb, 3'b000, 32'h7FC00000};
        if (ia && ib && (sa != sb)) return {4'b1000, 32'h7FC00000};
        if (ia) return {4'b0000, sa, 8'hFF, 23'h0};
        if (ib) return {4'b0000, sb, 8'hFF, 23'h0};
        if (za && zb) return {4'b0000, sa && sb, 31'h0};
        one = 300'd1;
        ma  = za ? 300'd0 : (300'({1'b1, a[22:0]}) << (int'(a[30:23]) - 1));
        mb  = zb ? 300'd0 : (300'({1'b1, b[22:0]}) << (int'(b[30:23]) - 1));
        if (sa == sb) begin mag = ma + mb; sgn = sa; end
        else if (ma >= mb) begin mag = ma - mb; sgn = sa; end
        else begin mag = mb - ma; sgn = sb; end
        if (mag == 0) return 36'h0;
        p = 0;
        for (int i = 0; i < 300; i++) if (mag[i]) p = i;
        e = p - 22;
        if (p > 23) begin
            sh   = p - 23;
            mant = mag >> sh;
            rem  = mag & ((one << sh) - one);
            half = one << (sh - 1);
            inx  = (rem != 0);
            up   = !rnd && ((rem > half) || ((rem == half) && mant[0]));
        end else begin
            mant = mag << (23 - p);
            inx  = 1'b0;
            up   = 1'b0;
        end
        if (up) mant = mant + one;
        if (mant[24]) begin mant = mant >> 1; e = e + 1; end
        if (e >= 255) return {4'b0101, sgn, rnd ? 31'h7F7FFFFF : 31'h7F800000};
        if (e <= 0) return {4'b0011, sgn, 31'h0};
        return {3'b000, inx, sgn, 8'(e), mant[22:0]};
    endfunction

    function automatic logic [31:0] rand_special();
        case ($urandom_range(0, 7))
            0: return 32'h00000000;
            1: return 32'h80000000;
            2: return 32'h7F800000;
            3: return 32'hFF800000;
            4: return 32'h7FC00000;
            5: return 32'h7F800001;
            6: return 32'h00000001;
            default: return 32'h7F7FFFFF;
        endcase
    endfunction

    function automatic logic [31:0] rand_b(input logic [31:0] a);
        int ne;
        logic [31:0] r;
        r  = $urandom();
        ne = int'(a[30:23]) + int'($urandom_range(0, 4)) - 2;
        if (ne < 0) ne = 0;
        if (ne > 255) ne = 255;
        case ($urandom_range(0, 4))
            0: return r;
            1: return {r[31], 8'(ne), r[22:0]};
            2: return {r[31], a[30:0] ^ {27'h0, r[3:0]}};
            3: return rand_special();
            default: return {r[31], a[30:23], r[22:0]};
        endcase
    endfunction

    // One clock with scoreboard checking; outputs are sampled at the following falling edge.
    task automatic step(input logic en, input logic vld, input logic [31:0] a, input logic [31:0] b,
                        input logic sub, input logic rnd);
        logic [36:0] snap;
        logic [35:0] e;
        snap    = {o_valid, o_flags, o_result};
        i_en    = en;
        i_valid = vld;
        i_A     = a;
        i_B     = b;
        i_sub   = sub;
        i_rnd   = rnd;
        if (en && vld) exp_q.push_back(model(a, b, sub, rnd));
        @(posedge clk);
        @(negedge clk);
        if (!en) begin
            chk("stall_hold", {27'h0, o_valid, o_flags, o_result}, {27'h0, snap});
        end else if (o_valid) begin
            if (exp_q.size() == 0) begin
                chk("spurious_valid", {63'h0, o_valid}, 64'h0);
            end else begin
                e = exp_q.pop_front();
                chk($sformatf("stream a=%h b=%h", a, b), {28'h0, o_flags, o_result}, {28'h0, e});
            end
        end
    endtask

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        sub;
        logic        rnd;
        logic [31:0] res;
        logic [3:0]  flags;
    } vec_t;

    localparam int NV = 19;
    vec_t tbl[NV];

    initial begin
        tbl[0]  = '{32'h3F800000, 32'h40000000, 1'b0, 1'b0, 32'h40400000, 4'b0000};
        tbl[1]  = '{32'h3F800000, 32'h33800000, 1'b0, 1'b0, 32'h3F800000, 4'b0001};
        tbl[2]  = '{32'h3F800000, 32'h33800000, 1'b0, 1'b1, 32'h3F800000, 4'b0001};
        tbl[3]  = '{32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 1'b0, 32'h7F800000, 4'b0101};
        tbl[4]  = '{32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 1'b1, 32'h7F7FFFFF, 4'b0101};
        tbl[5]  = '{32'h7F800000, 32'h7F800000, 1'b1, 1'b0, 32'h7FC00000, 4'b1000};
        tbl[6]  = '{32'h40400000, 32'h40400000, 1'b1, 1'b0, 32'h00000000, 4'b0000};
        tbl[7]  = '{32'h80000000, 32'h80000000, 1'b0, 1'b0, 32'h80000000, 4'b0000};
        tbl[8]  = '{32'h00000000, 32'h80000000, 1'b0, 1'b0, 32'h00000000, 4'b0000};
        tbl[9]  = '{32'h7F800001, 32'h3F800000, 1'b0, 1'b0, 32'h7FC00000, 4'b1000};
        tbl[10] = '{32'h7FC00001, 32'h3F800000, 1'b0, 1'b0, 32'h7FC00000, 4'b0000};
        tbl[11] = '{32'h7F800000, 32'h3F800000, 1'b0, 1'b0, 32'h7F800000, 4'b0000};
        tbl[12] = '{32'h3F800000, 32'h7F800000, 1'b1, 1'b0, 32'hFF800000, 4'b0000};
        tbl[13] = '{32'h00000001, 32'h3F800000, 1'b0, 1'b0, 32'h3F800000, 4'b0000};
        tbl[14] = '{32'h00800000, 32'h00800001, 1'b1, 1'b0, 32'h80000000, 4'b0011};
        tbl[15] = '{32'h3FC00000, 32'h3F800000, 1'b1, 1'b0, 32'h3F000000, 4'b0000};
        tbl[16] = '{32'h3F800000, 32'h33C00000, 1'b0, 1'b0, 32'h3F800001, 4'b0001};
        tbl[17] = '{32'h3F800000, 32'h33C00000, 1'b0, 1'b1, 32'h3F800000, 4'b0001};
        tbl[18] = '{32'h3F800001, 32'h3F800000, 1'b1, 1'b0, 32'h34000000, 4'b0000};

        i_rst = 1'b1; i_en = 1'b0; i_valid = 1'b0; i_A = '0; i_B = '0; i_sub = 1'b0; i_rnd = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", {63'h0, o_valid}, 64'h0);
        chk("rst_result", {32'h0, o_result}, 64'h0);
        chk("rst_flags", {60'h0, o_flags}, 64'h0);
        i_rst = 1'b0;
        i_en  = 1'b1;

        // Directed vectors: exact 3-cycle latency, then values held once o_valid drops.
        for (int i = 0; i < NV; i++) begin
            i_valid = 1'b1; i_A = tbl[i].a; i_B = tbl[i].b; i_sub = tbl[i].sub; i_rnd = tbl[i].rnd;
            @(posedge clk); @(negedge clk);
            i_valid = 1'b0; i_A = $urandom(); i_B = $urandom();
            chk($sformatf("vec%0d_lat1", i), {63'h0, o_valid}, 64'h0);
            @(posedge clk); @(negedge clk);
            chk($sformatf("vec%0d_lat2", i), {63'h0, o_valid}, 64'h0);
            @(posedge clk); @(negedge clk);
            chk($sformatf("vec%0d_valid", i), {63'h0, o_valid}, 64'h1);
            chk($sformatf("vec%0d_result", i), {32'h0, o_result}, {32'h0, tbl[i].res});
            chk($sformatf("vec%0d_flags", i), {60'h0, o_flags}, {60'h0, tbl[i].flags});
            @(posedge clk); @(negedge clk);
            chk($sformatf("vec%0d_drop", i), {63'h0, o_valid}, 64'h0);
            chk($sformatf("vec%0d_hold", i), {28'h0, o_flags, o_result}, {28'h0, tbl[i].flags, tbl[i].res});
        end

        // Four back-to-back ops with a two-cycle stall in the middle.
        step(1'b1, 1'b1, 32'h3F800000, 32'h40000000, 1'b0, 1'b0);
        step(1'b1, 1'b1, 32'h40400000, 32'h3F800000, 1'b1, 1'b0);
        step(1'b0, 1'b1, 32'hDEADBEEF, 32'h12345678, 1'b0, 1'b0);
        step(1'b0, 1'b1, 32'hCAFEF00D, 32'h0BADF00D, 1'b1, 1'b1);
        step(1'b1, 1'b1, 32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 1'b1);
        step(1'b1, 1'b1, 32'hC0A00000, 32'h3F000000, 1'b0, 1'b0);
        step(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        repeat (4) step(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        chk("b2b_drained", 64'(exp_q.size()), 64'h0);

        // Reset with two ops in flight, while i_en is low and i_valid high.
        step(1'b1, 1'b1, 32'h40000000, 32'h40000000, 1'b0, 1'b0);
        step(1'b1, 1'b1, 32'h3F800000, 32'h3F800000, 1'b0, 1'b0);
        i_rst = 1'b1; i_en = 1'b0; i_valid = 1'b1;
        @(posedge clk); @(negedge clk);
        chk("midrst_valid", {63'h0, o_valid}, 64'h0);
        chk("midrst_result", {32'h0, o_result}, 64'h0);
        chk("midrst_flags", {60'h0, o_flags}, 64'h0);
        i_rst = 1'b0;
        exp_q.delete();
        for (int k = 0; k < 5; k++) begin
            step(1'b1, 1'b0, 32'h3F800000, 32'h3F800000, 1'b0, 1'b0);
            chk($sformatf("postrst_idle%0d", k), {63'h0, o_valid}, 64'h0);
        end

        // Randomized stream with random stalls, scored against the reference model.
        for (int n = 0; n < 3000; n++) begin
            logic [31:0] a;
            a = ($urandom_range(0, 9) == 0) ? rand_special() : $urandom();
            step($urandom_range(0, 4) != 0, $urandom_range(0, 5) != 0, a, rand_b(a),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        repeat (4) step(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        chk("stream_drained", 64'(exp_q.size()), 64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/adder_fp_pipe.md
ADDER_FP_PIPE -- requirements
Module: adder_fp_pipe

Interface
REQ-001 Parameter SIZE, default 32, total IEEE-754 width; legal values 16, 32, 64.
REQ-002 Parameter EXPONENT, default 5 + ($clog2(SIZE)-4)*3, exponent field width (5/8/11).
REQ-003 Parameter FRACTION, default SIZE-EXPONENT-1, stored fraction width.
REQ-004 Parameter BIAS, default 2**(EXPONENT-1)-1, exponent bias.
REQ-005 i_clk  input  1  single clock; all state updates on rising edge.
REQ-006 i_rst  input  1  synchronous, active-high reset.
REQ-007 i_en  input  1  pipeline advance; low freezes every stage register.
REQ-008 i_valid  input  1  i_A/i_B/i_sub/i_rnd qualify an operation this cycle.
REQ-009 i_A, i_B  input  SIZE  IEEE-754 operands.
REQ-010 i_sub  input  1  1 = compute A-B, 0 = A+B.
REQ-011 i_rnd  input  1  rounding mode: 0 = round-nearest-even (RNE), 1 = round-toward-zero (RTZ).
REQ-012 o_valid  output  1  o_result/flags valid this cycle.
REQ-013 o_result  output  SIZE  IEEE-754 sum/difference.
REQ-014 o_flags  output  4  {invalid, overflow, underflow, inexact}, bit 3 = invalid.

Function
REQ-015 Pipeline SHALL have exactly 3 register stages; o_valid SHALL assert 3 advancing cycles (i_en high) after i_valid sampled high.
REQ-016 Stage 1 SHALL unpack, apply i_sub to B sign, swap so the larger magnitude is operand X, align the smaller by exponent difference with guard, round and sticky bits (sticky = OR of all shifted-out bits; shift >= FRACTION+3 yields sticky only).
REQ-017 Stage 2 SHALL add/subtract FRACTION+4-bit significands per effective operation and compute leading-zero count.
REQ-018 Stage 3 SHALL normalise (right 1 on carry, left by LZC), round per i_rnd, renormalise on rounding carry, pack, and set flags.
REQ-019 RNE SHALL round up when G=1 and (R|S|LSB)=1; RTZ SHALL truncate.
REQ-020 Subnormal inputs SHALL be treated as zero of the same sign (flush-to-zero).
REQ-021 Results with biased exponent <= 0 after rounding SHALL be flushed to signed zero with underflow=1 and inexact=1.
REQ-022 Exponent overflow SHALL set overflow=1, inexact=1; result = signed infinity in RNE, signed max-finite in RTZ.
REQ-023 Any NaN input, or inf minus inf (effective), SHALL produce canonical qNaN (sign 0, exp all ones, fraction MSB 1, rest 0); invalid=1 only for inf-inf or signalling NaN input.
REQ-024 One infinity operand (no invalid case) SHALL return that infinity, flags 0.
REQ-025 Exact cancellation SHALL return +0; (-0)+(-0) SHALL return -0; (+0)+(-0) SHALL return +0.
REQ-026 inexact SHALL be set whenever G|R|S is nonzero before rounding.
REQ-027 With i_en low, all stage registers including valid bits SHALL hold; o_valid/o_result/o_flags remain stable.
REQ-028 Back-to-back operations at one per advancing cycle SHALL be supported with no bubbles.
REQ-029 o_result/o_flags SHALL hold the last valid values when o_valid is low (no clearing).

Reset
REQ-030 While i_rst is high on a clock edge, all stage valid bits, o_valid, o_result and o_flags SHALL become 0, regardless of i_en.
REQ-031 Operations in flight when reset asserts SHALL be discarded; first o_valid after reset requires a new i_valid.
REQ-032 Reset SHALL take priority over i_en and i_valid in the same cycle.

Verification (SIZE=32)
REQ-033 A=0x3F800000, B=0x40000000, i_sub=0, RNE -> 3 cycles later o_result=0x40400000, flags=0000.
REQ-034 A=0x3F800000, B=0x33800000 (2^-24), RNE and RTZ -> o_result=0x3F800000, inexact=1 (tie to even).
REQ-035 A=B=0x7F7FFFFF, add: RNE -> 0x7F800000 flags 0101; RTZ -> 0x7F7FFFFF flags 0101.
REQ-036 A=0x7F800000, B=0x7F800000, i_sub=1 -> 0x7FC00000, flags 1000; A=0x40400000 minus itself -> 0x00000000, flags 0000.
REQ-037 Stream 4 ops back-to-back, drop i_en for 2 cycles mid-stream -> outputs in order, no loss/duplication, outputs frozen during stall.
REQ-038 Assert i_rst with 2 ops in flight -> o_valid=0, o_result=0 next cycle; no stale result emerges afterwards.
